occ_block_builder: RTL
======================

OCC_BLOCK_BUILDER -- requirements
Module: occ_block_builder

Interface
REQ-001 SHALL have parameter PAD_SYM, default 3'd4, the 3-bit code written into unused BwtSlice entries of a short final block.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port sym, input, 3 bits: BWT symbol (0=A, 1=C, 2=G, 3=T, 4..7 are stored but not counted).
REQ-005 SHALL have ports sym_valid (input, 1), sym_last (input, 1) and sym_ready (output, 1): input symbol handshake; sym_last marks the final symbol of a sequence.
REQ-006 SHALL have port occ_block, output, 256 bits, in BwaMemDefines OccBlock layout (OccA, OccC, OccG, OccT 40 bits each; BwtSlice 32x3 bits, index 0 = first symbol).
REQ-007 SHALL have ports blk_valid (output, 1), blk_ready (input, 1) and blk_last (output, 1): output block handshake; blk_last marks the final block of a sequence.
REQ-008 SHALL have port busy, output, 1 bit: high while a partial block, held block or pending tail exists.

Function
REQ-009 SHALL implement states FILL, HOLD and TAIL; sym_ready = (state == FILL).
REQ-010 SHALL accept a symbol on a cycle with sym_valid and sym_ready both high, writing it to BwtSlice[idx], where idx is a 5-bit slot index.
REQ-011 SHALL keep four 40-bit running counters (A, C, G, T), incremented on acceptance of codes 0..3 only and wrapping modulo 2^40.
REQ-012 SHALL load OccA..OccT of each block with the running counters as they stood before that block's first symbol.
REQ-013 SHALL close a block on acceptance with idx == 31 or with sym_last; the block is registered on that edge, blk_valid rises the next cycle, and the state moves to HOLD.
REQ-014 SHALL fill slots idx+1..31 of a block closed by sym_last with PAD_SYM.
REQ-015 SHALL drive blk_last = 1 for a block closed by sym_last, unless REQ-025 applies.
REQ-016 SHALL hold occ_block, blk_valid and blk_last stable in HOLD until blk_ready is high.
REQ-017 SHALL, on a HOLD handshake, go to FILL with idx = 0 and clear blk_valid in the same edge; after a blk_last block, also zero the running counters.
REQ-018 SHALL give no symbol acceptance in HOLD or TAIL, so acceptance and output handshake never coincide; throughput is 32 symbols per 33 cycles with blk_ready held high.
REQ-019 SHALL let sym_last with idx == 0 produce a one-symbol block (slots 1..31 = PAD_SYM).
REQ-020 SHALL assert busy when idx != 0 or state != FILL.

Reset
REQ-021 SHALL, on rst, set state = FILL, idx = 0, counters = 0, occ_block = 0, blk_valid = 0, blk_last = 0 and busy = 0; sym_ready is 1 the cycle after.
REQ-022 SHALL discard any partial or held block when rst is asserted mid-operation; no block is emitted for it.

Configuration
REQ-023 SHALL use macro OCC_BLOCK_TAIL_EN.
REQ-024 SHALL, when OCC_BLOCK_TAIL_EN is undefined, have no TAIL state; behaviour is REQ-009..REQ-022 only.
REQ-025 SHALL, when OCC_BLOCK_TAIL_EN is defined and the block closed by sym_last was full (idx == 31), send that block with blk_last = 0, then enter TAIL.
REQ-026 SHALL, in TAIL, emit one extra block: final totals in OccA..OccT, all 32 slots = PAD_SYM, blk_last = 1, same HOLD handshake; afterwards counters are zeroed.

Verification
REQ-027 SHALL cover: 32 symbols A,C,G,T repeated, sym_last on the 32nd -> one block, OccA..T = 0, BwtSlice[k] = k mod 4, blk_last = 1; blk_valid rises 1 cycle after the 32nd accept.
REQ-028 SHALL cover: 40 symbols all G, last on the 40th -> block0 Occ = {0,0,0,0}; block1 OccG = 32, slots 0..7 = 2, slots 8..31 = 4, blk_last = 1.
REQ-029 SHALL cover: blk_ready held low 10 cycles after a block closes -> occ_block stable, sym_ready = 0 throughout, and no symbol is lost once blk_ready rises.
REQ-030 SHALL cover: 5 symbols, then rst, then 3 symbols with last -> exactly one block, holding only the 3 post-reset symbols, counters based at 0.
REQ-031 SHALL cover: a symbol code 5 mid-block -> stored in its slot, and no counter increments.
REQ-032 SHALL cover: OCC_BLOCK_TAIL_EN defined, 32 symbols of T with last -> first block blk_last = 0, second block OccT = 32, all slots = 4, blk_last = 1.

Source files
------------

// File: rtl/occ_block_builder.sv
// Packs a stream of 3-bit BWT symbols into 256-bit OccBlocks:
// occ_block = {BwtSlice[31..0] (slot k at bits 160+3k), OccT, OccG, OccC, OccA (bits 39:0)}.
// Defining OCC_BLOCK_TAIL_EN adds a trailing totals-only block after a sequence that ends on a full block.
//
// Handshakes: a symbol transfers on a rising edge where sym_valid && sym_ready; a block
// transfers on a rising edge where blk_valid && blk_ready. Once raised, blk_valid,
// occ_block and blk_last stay put until that transfer.
module occ_block_builder #(
    parameter logic [2:0] PAD_SYM = 3'd4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   sym,
    input  logic         sym_valid,
    input  logic         sym_last,
    output logic         sym_ready,
    output logic [255:0] occ_block,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic         blk_last,
    output logic         busy,
    output logic [1:0]   dbg_state
);

`ifdef OCC_BLOCK_TAIL_EN
    typedef enum logic [1:0] {FILL = 2'd0, HOLD = 2'd1, TAIL = 2'd2} state_t;
`else
    typedef enum logic [1:0] {FILL = 2'd0, HOLD = 2'd1} state_t;
`endif

    state_t      state;
    state_t      state_n;
    logic [4:0]  idx;
    logic [39:0] cnt [4];
    logic [39:0] base [4];
    logic [39:0] occ_base [4];
    logic [95:0] slice_q;
    logic [95:0] slice_n;
    logic        accept;
    logic        close_blk;
    logic        full_last;
`ifdef OCC_BLOCK_TAIL_EN
    logic        tail_pend;
`endif

    assign sym_ready = (state == FILL);
    assign accept    = sym_valid && sym_ready;
    assign close_blk = accept && (sym_last || idx == 5'd31);
    assign busy      = (idx != 5'd0) || (state != FILL);
    assign dbg_state = state;

`ifdef OCC_BLOCK_TAIL_EN
    assign full_last = sym_last && (idx == 5'd31);
`else
    assign full_last = 1'b0;
`endif

    // Slice as it stands after this symbol: new symbol in slot idx, padding above it.
    always_comb begin
        slice_n = slice_q;
        for (int k = 0; k < 32; k++) begin
            if (5'(k) == idx)
                slice_n[3*k +: 3] = sym;
            else if (5'(k) > idx)
                slice_n[3*k +: 3] = PAD_SYM;
        end
    end

    // The block's first symbol has not been captured into base yet when idx is 0.
    always_comb begin
        for (int i = 0; i < 4; i++)
            occ_base[i] = (idx == 5'd0) ? cnt[i] : base[i];
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= FILL;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            FILL: if (close_blk) state_n = HOLD;
`ifdef OCC_BLOCK_TAIL_EN
            HOLD: if (blk_ready) state_n = tail_pend ? TAIL : FILL;
            TAIL: state_n = HOLD;
`else
            HOLD: if (blk_ready) state_n = FILL;
`endif
            default: state_n = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= 5'd0;
            slice_q   <= '0;
            occ_block <= '0;
            blk_valid <= 1'b0;
            blk_last  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt[i]  <= '0;
                base[i] <= '0;
            end
`ifdef OCC_BLOCK_TAIL_EN
            tail_pend <= 1'b0;
`endif
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        slice_q <= slice_n;
                        idx     <= close_blk ? 5'd0 : idx + 5'd1;
                        if (idx == 5'd0) begin
                            for (int i = 0; i < 4; i++)
                                base[i] <= cnt[i];
                        end
                        if (!sym[2])
                            cnt[sym[1:0]] <= cnt[sym[1:0]] + 40'd1;
                        if (close_blk) begin
                            occ_block <= {slice_n, occ_base[3], occ_base[2], occ_base[1], occ_base[0]};
                            blk_valid <= 1'b1;
                            blk_last  <= sym_last && !full_last;
`ifdef OCC_BLOCK_TAIL_EN
                            tail_pend <= full_last;
`endif
                        end
                    end
                end
                HOLD: begin
                    if (blk_ready) begin
                        blk_valid <= 1'b0;
                        idx       <= 5'd0;
                        // End of sequence: the next one counts from zero.
                        if (blk_last) begin
                            for (int i = 0; i < 4; i++)
                                cnt[i] <= '0;
                        end
                    end
                end
`ifdef OCC_BLOCK_TAIL_EN
                TAIL: begin
                    occ_block <= {{32{PAD_SYM}}, cnt[3], cnt[2], cnt[1], cnt[0]};
                    blk_valid <= 1'b1;
                    blk_last  <= 1'b1;
                    tail_pend <= 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
